tlul_sram_responder: RTL and testbench

//  TL-UL device-side adapter, the responder counterpart of the core's host adapters. Accepts
//  A-channel requests from the crossbar and drives a simple req/gnt/rvalid SRAM-style port.

---
 rtl/tlul_sram_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_tlul_sram_responder.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_sram_responder.sv
// TL-UL device-side responder: accepts A-channel requests, drives a
// req/gnt/rvalid SRAM port and returns in-order D-channel responses.
//
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   tl_i / tl_o       TL-UL host-to-device / device-to-host bundles
//   req_o, gnt_i      SRAM request / grant (consumed on req_o & gnt_i)
//   we_o, addr_o      write enable, word address
//   wdata_o, wmask_o  write data, per-bit write mask (0 for reads)
//   rdata_i, rvalid_i read data and its in-order valid pulse
//   rerror_i          uncorrectable read error, qualified by rvalid_i

package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_sram_responder
    import tlul_pkg::*;
#(
    parameter int SramAw      = 12,
    parameter int Outstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tl_h2d_t           tl_i,
    output tl_d2h_t           tl_o,
    output logic              req_o,
    input  logic              gnt_i,
    output logic              we_o,
    output logic [SramAw-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       wmask_o,
    input  logic [31:0]       rdata_i,
    input  logic              rvalid_i,
    input  logic              rerror_i
);

    localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int CntW = $clog2(Outstanding + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Outstanding - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(Outstanding);

    typedef struct packed {
        logic       is_read;
        logic       err;
        logic [1:0] size;
        logic [7:0] source;
    } meta_t;

    typedef struct packed {
        logic [31:0] data;
        logic        rerr;
    } rd_t;

    // ---------------- request check ----------------
    logic [3:0] lanes;
    logic       op_ok;
    logic       size_ok;
    logic       align_ok;
    logic       mask_ok;
    logic       full_ok;
    logic       a_err;
    logic       is_get;

    always_comb begin
        lanes    = 4'b0000;
        align_ok = 1'b1;
        unique case (tl_i.a_size)
            2'd0: lanes = 4'b0001 << tl_i.a_address[1:0];
            2'd1: begin
                lanes    = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
                align_ok = ~tl_i.a_address[0];
            end
            2'd2: begin
                lanes    = 4'b1111;
                align_ok = (tl_i.a_address[1:0] == 2'b00);
            end
            default: lanes = 4'b0000;
        endcase
    end

    assign is_get  = (tl_i.a_opcode == Get);
    assign op_ok   = is_get
                   | (tl_i.a_opcode == PutFullData)
                   | (tl_i.a_opcode == PutPartialData);
    assign size_ok = (tl_i.a_size != 2'd3);
    assign mask_ok = ((tl_i.a_mask & ~lanes) == 4'b0000);
    assign full_ok = (tl_i.a_opcode != PutFullData)
                   | ((tl_i.a_mask & lanes) == lanes);
    assign a_err   = ~(op_ok & size_ok & align_ok
                     & mask_ok & full_ok);

    // ---------------- state ----------------
    meta_t          meta_q [Outstanding];
    rd_t            rd_q   [Outstanding];
    logic [PtrW-1:0] m_wptr, m_rptr;
    logic [PtrW-1:0] r_wptr, r_rptr;
    logic [CntW-1:0] count;
    logic [CntW-1:0] rcnt;
    logic [CntW-1:0] pend_rd;
    // Set once a read has been granted since reset; stale rvalids
    // from before a reset arrive with this clear and are dropped.
    logic            armed;

    // ---------------- accept path ----------------
    logic room;
    logic a_ready;
    logic accept;
    logic gnt_rd;

    assign room    = (count < MaxCnt);
    assign req_o   = rst_ni & tl_i.a_valid & room & ~a_err;
    assign a_ready = rst_ni & room & (a_err | gnt_i);
    assign accept  = tl_i.a_valid & a_ready;
    assign gnt_rd  = req_o & gnt_i & is_get;

    assign we_o    = ~is_get;
    assign addr_o  = tl_i.a_address[SramAw+1:2];
    assign wdata_o = tl_i.a_data;
    assign wmask_o = is_get ? 32'h0 : {{8{tl_i.a_mask[3]}},
                                       {8{tl_i.a_mask[2]}},
                                       {8{tl_i.a_mask[1]}},
                                       {8{tl_i.a_mask[0]}}};

    // ---------------- response path ----------------
    meta_t head;
    rd_t   rhead;
    logic  d_valid;
    logic  pop;
    logic  pop_rd;
    logic  rpush;
    logic  good_rd;

    assign head    = meta_q[m_rptr];
    assign rhead   = rd_q[r_rptr];
    assign d_valid = rst_ni & (count != '0)
                   & (~head.is_read | head.err | (rcnt != '0));
    assign pop     = d_valid & tl_i.d_ready;
    assign pop_rd  = pop & head.is_read & ~head.err;
    assign rpush   = rvalid_i & (pend_rd != '0);
    assign good_rd = head.is_read & ~head.err;

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = d_valid;
        tl_o.d_opcode = head.is_read ? AccessAckData : AccessAck;
        tl_o.d_size   = head.size;
        tl_o.d_source = head.source;
        tl_o.d_data   = (good_rd & ~rhead.rerr) ? rhead.data : 32'h0;
        tl_o.d_error  = head.err | (good_rd & rhead.rerr);
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            m_wptr  <= '0;
            m_rptr  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            count   <= '0;
            rcnt    <= '0;
            pend_rd <= '0;
            armed   <= 1'b0;
        end else begin
            if (accept)
                m_wptr <= (m_wptr == LastPtr) ? '0 : m_wptr + 1'b1;
            if (pop)
                m_rptr <= (m_rptr == LastPtr) ? '0 : m_rptr + 1'b1;
            if (rpush)
                r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
            if (pop_rd)
                r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;

            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            unique case ({rpush, pop_rd})
                2'b10:   rcnt <= rcnt + 1'b1;
                2'b01:   rcnt <= rcnt - 1'b1;
                default: rcnt <= rcnt;
            endcase

            unique case ({gnt_rd, rpush})
                2'b10:   pend_rd <= pend_rd + 1'b1;
                2'b01:   pend_rd <= pend_rd - 1'b1;
                default: pend_rd <= pend_rd;
            endcase

            if (gnt_rd)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept)
            meta_q[m_wptr] <= '{is_read: is_get,
                                err:     a_err,
                                size:    tl_i.a_size,
                                source:  tl_i.a_source};
        if (rpush)
            rd_q[r_wptr] <= '{data: rdata_i, rerr: rerror_i};
    end

    logic unused_bits;
    assign unused_bits = ^{tl_i.a_param, tl_i.a_user,
                           tl_i.a_address[31:SramAw+2]};

    rvalid_needs_read: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (rvalid_i && armed) |-> (pend_rd != '0)
    );

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Testbench for tlul_sram_responder: SRAM model plus a scoreboard of
// expected D-channel responses built from the A-channel stimulus.

module tb_tlul_sram_responder;
    import tlul_pkg::*;

    localparam int Aw   = 12;
    localparam int Outs = 2;

    logic          clk = 1'b0;
    logic          rst_ni;
    tl_h2d_t       tl_i;
    tl_h2d_t       a_req;
    logic          d_rdy;
    tl_d2h_t       tl_o;
    logic          req_o;
    logic          gnt_i;
    logic          we_o;
    logic [Aw-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic [31:0]   wmask_o;
    logic [31:0]   rdata_i;
    logic          rvalid_i;
    logic          rerror_i;

    always #5 clk = ~clk;

    always_comb begin
        tl_i         = a_req;
        tl_i.d_ready = d_rdy;
    end

    tlul_sram_responder #(.SramAw(Aw), .Outstanding(Outs)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .req_o   (req_o),
        .gnt_i   (gnt_i),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .wmask_o (wmask_o),
        .rdata_i (rdata_i),
        .rvalid_i(rvalid_i),
        .rerror_i(rerror_i)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem  [4096];
    logic [31:0] sram_mem [4096];
    int          cur_lat = 0;

    function automatic logic ref_err(tl_h2d_t r);
        int   nbytes;
        int   lanes;
        logic bad;
        bad = 1'b0;
        if (!(r.a_opcode inside {3'd0, 3'd1, 3'd4})) bad = 1'b1;
        if (r.a_size > 2) begin
            bad = 1'b1;
        end else begin
            nbytes = 1 << r.a_size;
            if ((r.a_address % nbytes) != 0) bad = 1'b1;
            lanes = (((1 << nbytes) - 1) << r.a_address[1:0]) & 15;
            if ((r.a_mask & ~lanes[3:0]) != 0) bad = 1'b1;
            if (r.a_opcode == 3'd0 && (r.a_mask & lanes[3:0]) != lanes[3:0])
                bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic push_exp(tl_h2d_t r);
        exp_t e;
        int   w;
        w      = int'(r.a_address[Aw+1:2]);
        e.err  = ref_err(r);
        e.op   = (r.a_opcode == 3'd4) ? 3'd1 : 3'd0;
        e.size = r.a_size;
        e.src  = r.a_source;
        e.data = 32'h0;
        e.acc  = cyc;
        e.lat  = cur_lat;
        if (!e.err) begin
            if (r.a_opcode == 3'd4) begin
                if (w == 'h3F) e.err = 1'b1;
                else e.data = ref_mem[w];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (r.a_mask[b]) ref_mem[w][8*b +: 8] = r.a_data[8*b +: 8];
            end
        end
        sb.push_back(e);
    endtask

    // ---------------- SRAM model ----------------
    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } rd_t;

    rd_t  rq[$];
    int   lat       = 1;
    bit   gnt_rand  = 0;
    bit   dr_rand   = 0;
    logic d_rdy_set = 1'b1;
    bit   req_seen  = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        d_rdy = dr_rand ? 1'($urandom_range(0, 1)) : d_rdy_set;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            rvalid_i = 1'b1;
            rdata_i  = rq[0].d;
            rerror_i = rq[0].e;
            void'(rq.pop_front());
        end else begin
            rvalid_i = 1'b0;
            rdata_i  = 32'h0;
            rerror_i = 1'b0;
        end
    end

    always @(negedge clk) begin
        rd_t r;
        if (!rst_ni) begin
            rq.delete();
        end else if (req_o && gnt_i) begin
            if (we_o) begin
                sram_mem[addr_o] = (sram_mem[addr_o] & ~wmask_o)
                                 | (wdata_o & wmask_o);
            end else begin
                r.d = sram_mem[addr_o];
                r.e = (addr_o == 12'h3F);
                r.due = cyc + lat;
                rq.push_back(r);
            end
        end
        if (req_o) req_seen = 1;
    end

    // ---------------- D-channel monitor ----------------
    bit          hold_v = 0;
    logic [45:0] held;

    always @(negedge clk) begin
        exp_t        e;
        logic [45:0] cur;
        cur = {tl_o.d_opcode, tl_o.d_size, tl_o.d_source,
               tl_o.d_data, tl_o.d_error};
        if (!rst_ni) begin
            sb.delete();
            hold_v = 0;
        end else begin
            if (hold_v) begin
                chk("d_valid_held", tl_o.d_valid, 1);
                chk("d_stable", cur, held);
            end
            hold_v = tl_o.d_valid && !tl_i.d_ready;
            held   = cur;
            if (tl_o.d_valid && tl_i.d_ready) begin
                if (sb.size() == 0) begin
                    chk("d_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("d_opcode", tl_o.d_opcode, e.op);
                    chk("d_size",   tl_o.d_size,   e.size);
                    chk("d_source", tl_o.d_source, e.src);
                    chk("d_data",   tl_o.d_data,   e.data);
                    chk("d_error",  tl_o.d_error,  e.err);
                    chk("d_zero", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 0);
                    if (e.lat != 0) chk("d_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_a(logic [2:0] op, logic [31:0] addr,
                           logic [1:0] size, logic [3:0] mask,
                           logic [31:0] data, logic [7:0] src);
        a_req           = '0;
        a_req.a_valid   = 1'b1;
        a_req.a_opcode  = op;
        a_req.a_address = addr;
        a_req.a_size    = size;
        a_req.a_mask    = mask;
        a_req.a_data    = data;
        a_req.a_source  = src;
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tl_o.a_ready) begin
                ok = 1;
                push_exp(a_req);
                break;
            end
        end
        if (!ok) chk("a_timeout", 0, 1);
        @(posedge clk);
        #1;
        a_req.a_valid = 1'b0;
    endtask

    task automatic send(logic [2:0] op, logic [31:0] addr,
                        logic [1:0] size, logic [3:0] mask,
                        logic [31:0] data, logic [7:0] src);
        drive_a(op, addr, size, mask, data, src);
        wait_accept();
    endtask

    task automatic drain(int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && rq.size() == 0 && !tl_o.d_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // error-case table: opcode, addr, size, mask
    logic [2:0]  eop   [5] = '{3'd4, 3'd3, 3'd0, 3'd1, 3'd4};
    logic [31:0] eaddr [5] = '{32'h2, 32'h0, 32'h4, 32'h5, 32'h8};
    logic [1:0]  esize [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd3};
    logic [3:0]  emask [5] = '{4'hF, 4'hF, 4'h3, 4'h4, 4'hF};

    initial begin
        a_req  = '0;
        rst_ni = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i]  = 32'h0;
            sram_mem[i] = 32'h0;
        end
        ref_mem[4]  = 32'hDEADBEEF;
        sram_mem[4] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d_valid", tl_o.d_valid, 0);
        chk("rst_a_ready", tl_o.a_ready, 0);
        chk("rst_req", req_o, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // 1: plain read
        cur_lat = 2;
        send(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd3);
        drain(50);

        // 2: partial byte write then read back
        cur_lat = 1;
        drive_a(3'd1, 32'h21, 2'd0, 4'h2, 32'h0000AB00, 8'd5);
        #1;
        chk("t2_req", req_o, 1);
        chk("t2_we", we_o, 1);
        chk("t2_addr", addr_o, 12'h8);
        chk("t2_wmask", wmask_o, 32'h0000FF00);
        wait_accept();
        cur_lat = 2;
        send(3'd4, 32'h20, 2'd2, 4'hF, 32'h0, 8'd6);
        drain(50);

        // 3: erroneous requests never reach the SRAM
        req_seen = 0;
        cur_lat  = 1;
        for (int i = 0; i < 5; i++)
            send(eop[i], eaddr[i], esize[i], emask[i], 32'h1234, 8'(10 + i));
        drain(50);
        chk("t3_req_never", req_seen, 0);

        // 4: backpressure fills the outstanding slots
        cur_lat   = 0;
        d_rdy_set = 1'b0;
        @(posedge clk);
        #1;
        send(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd1);
        send(3'd4, 32'h20, 2'd2, 4'hF, 32'h0, 8'd2);
        drive_a(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_a_ready_full", tl_o.a_ready, 0);
        end
        @(posedge clk);
        #1;
        d_rdy_set = 1'b1;
        wait_accept();
        drain(50);

        // 5: write waits behind a slow read; read hits a bad word
        lat     = 3;
        cur_lat = 4;
        send(3'd4, 32'hFC, 2'd2, 4'hF, 32'h0, 8'd9);
        cur_lat = 0;
        send(3'd0, 32'h40, 2'd2, 4'hF, 32'h55AA55AA, 8'd10);
        drain(50);
        lat     = 1;
        cur_lat = 2;
        send(3'd4, 32'h40, 2'd2, 4'hF, 32'h0, 8'd11);
        drain(50);

        // 6: reset with reads in flight
        lat     = 5;
        cur_lat = 0;
        send(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd1);
        send(3'd4, 32'h20, 2'd2, 4'hF, 32'h0, 8'd2);
        rst_ni = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_d_valid", tl_o.d_valid, 0);
        chk("t6_a_ready", tl_o.a_ready, 0);
        chk("t6_req", req_o, 0);
        @(posedge clk);
        #1;
        rst_ni  = 1'b1;
        lat     = 1;
        cur_lat = 2;
        send(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd4);
        drain(50);

        // 7: random traffic with random grant and d_ready
        cur_lat  = 0;
        lat      = 2;
        gnt_rand = 1;
        dr_rand  = 1;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [1:0]  sz;
            logic [31:0] ad;
            logic [3:0]  mk;
            int          pick;
            pick = $urandom_range(0, 2);
            op   = (pick == 0) ? 3'd4 : ((pick == 1) ? 3'd0 : 3'd1);
            sz   = 2'($urandom_range(0, 2));
            ad   = {$urandom_range(0, 31), 2'b00};
            if (sz == 2'd0) ad[1:0] = 2'($urandom_range(0, 3));
            if (sz == 2'd1) ad[1]   = 1'($urandom_range(0, 1));
            mk = (sz == 2'd2) ? 4'hF
               : (sz == 2'd1) ? (ad[1] ? 4'hC : 4'h3)
               : (4'h1 << ad[1:0]);
            if ($urandom_range(0, 9) == 0) mk = 4'hF;
            send(op, ad, sz, mk, $urandom, 8'(i));
        end
        drain(400);
        gnt_rand = 0;
        dr_rand  = 0;
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
